afisaj_multiplexat: RTL and testbench

- Consumes the four BCD digits (mii, sute, zeci, unitati) produced by the control unit.
- Drives a 4-digit, time-multiplexed 7-segment display: one anode per slot, DIV clocks per slot, at a 2.5 MHz system clock.
- Latches a digit snapshot once per frame, so a frame never shows mixed old and new values.
- Provides leading-zero blanking, an anti-ghosting guard interval and a display enable.

---
 rtl/afisaj_pkg.sv | 22 ++
 rtl/decod_bcd_7seg.sv | 26 ++
 rtl/afisaj_multiplexat.sv | 118 +++++++++++
 tb/tb_afisaj_multiplexat.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/afisaj_pkg.sv
// rtl/afisaj_pkg.sv - shared segment patterns and slot indices for the multiplexed display
package afisaj_pkg;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  localparam logic [1:0] IDX_U = 2'd0;
  localparam logic [1:0] IDX_Z = 2'd1;
  localparam logic [1:0] IDX_S = 2'd2;
  localparam logic [1:0] IDX_M = 2'd3;

endpackage

// File: rtl/decod_bcd_7seg.sv
// rtl/decod_bcd_7seg.sv - BCD to active-high 7-segment decoder, non-BCD codes show a dash
module decod_bcd_7seg
  import afisaj_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_MINUS;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_MINUS;
    endcase
  end

endmodule

// File: rtl/afisaj_multiplexat.sv
// rtl/afisaj_multiplexat.sv - 4-digit multiplexed 7-segment driver with per-frame snapshot and blanking
module afisaj_multiplexat
  import afisaj_pkg::*;
#(
  parameter int DIV           = 2500,
  parameter int GARDA         = 2,
  parameter int SEG_ACTIV_JOS = 1,
  parameter int AN_ACTIV_JOS  = 1,
  parameter int BLANK_ZERO    = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] mii,
  input  logic [3:0] sute,
  input  logic [3:0] zeci,
  input  logic [3:0] unitati,
  input  logic       en,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       cadru
);

  localparam int              CW      = (DIV <= 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);
  localparam logic [3:0]      AN_OFF  = (AN_ACTIV_JOS != 0) ? 4'hF : 4'h0;
  localparam logic [6:0]      SEG_OFF = (SEG_ACTIV_JOS != 0) ? 7'h7F : 7'h00;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_snap_m, r_snap_s, r_snap_z, r_snap_u;
  logic          r_prim;
  logic          r_cadru;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  logic       w_tick;
  logic       w_load;
  logic [3:0] w_digit;
  logic [6:0] w_seg_raw;
  logic       w_blank;
  logic       w_show;
  logic [3:0] w_an_act;

  assign w_tick = (r_cnt == CNT_MAX);
  assign w_load = r_prim | (w_tick & (r_idx == IDX_M));

  always_comb begin
    w_digit = r_snap_u;
    case (r_idx)
      IDX_U: w_digit = r_snap_u;
      IDX_Z: w_digit = r_snap_z;
      IDX_S: w_digit = r_snap_s;
      IDX_M: w_digit = r_snap_m;
      default: w_digit = r_snap_u;
    endcase
  end

  // A slot is blank only when it and every more significant digit are zero.
  always_comb begin
    w_blank = 1'b0;
    if (BLANK_ZERO != 0) begin
      case (r_idx)
        IDX_M: w_blank = (r_snap_m == 4'd0);
        IDX_S: w_blank = (r_snap_m == 4'd0) && (r_snap_s == 4'd0);
        IDX_Z: w_blank = (r_snap_m == 4'd0) && (r_snap_s == 4'd0) && (r_snap_z == 4'd0);
        default: w_blank = 1'b0;
      endcase
    end
  end

  decod_bcd_7seg u_decod (
    .i_bcd (w_digit),
    .o_seg (w_seg_raw)
  );

  assign w_show   = en && (int'(r_cnt) >= GARDA) && !w_blank;
  assign w_an_act = 4'b0001 << r_idx;

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_cnt    <= '0;
      r_idx    <= IDX_U;
      r_snap_m <= 4'd0;
      r_snap_s <= 4'd0;
      r_snap_z <= 4'd0;
      r_snap_u <= 4'd0;
      r_prim   <= 1'b1;
      r_cadru  <= 1'b0;
      r_an     <= AN_OFF;
      r_seg    <= SEG_OFF;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) r_idx <= r_idx + 2'd1;

      r_cadru <= w_load;
      if (w_load) begin
        r_snap_m <= mii;
        r_snap_s <= sute;
        r_snap_z <= zeci;
        r_snap_u <= unitati;
        r_prim   <= 1'b0;
      end

      if (w_show) begin
        r_an  <= (AN_ACTIV_JOS != 0) ? ~w_an_act : w_an_act;
        r_seg <= (SEG_ACTIV_JOS != 0) ? ~w_seg_raw : w_seg_raw;
      end else begin
        r_an  <= AN_OFF;
        r_seg <= SEG_OFF;
      end
    end
  end

  assign seg   = r_seg;
  assign an    = r_an;
  assign cadru = r_cadru;

endmodule

// File: tb/tb_afisaj_multiplexat.sv
// tb/tb_afisaj_multiplexat.sv - directed self-checking bench for afisaj_multiplexat (DIV=4, GARDA=1)
module tb_afisaj_multiplexat;

  logic       clk = 1'b0;
  logic       clr;
  logic       en;
  logic [3:0] mii, sute, zeci, unitati;
  logic [6:0] seg, seg_b;
  logic [3:0] an, an_b;
  logic       cadru, cadru_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  afisaj_multiplexat #(.DIV(4), .GARDA(1), .SEG_ACTIV_JOS(1), .AN_ACTIV_JOS(1), .BLANK_ZERO(1)) dut (
    .clk(clk), .clr(clr), .mii(mii), .sute(sute), .zeci(zeci), .unitati(unitati),
    .en(en), .seg(seg), .an(an), .cadru(cadru)
  );

  afisaj_multiplexat #(.DIV(4), .GARDA(1), .SEG_ACTIV_JOS(1), .AN_ACTIV_JOS(1), .BLANK_ZERO(0)) dut_nb (
    .clk(clk), .clr(clr), .mii(mii), .sute(sute), .zeci(zeci), .unitati(unitati),
    .en(en), .seg(seg_b), .an(an_b), .cadru(cadru_b)
  );

  // Observation m of a frame reflects cnt=m%4, idx=m/4; m==15 is the load edge.
  task automatic test_reset;
    clr = 1'b0; en = 1'b1;
    mii = 4'd1; sute = 4'd2; zeci = 4'd3; unitati = 4'd4;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an got=%h exp=F", an); end
    checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7F", seg); end
    checks++; if (cadru !== 1'b0) begin failures++; $display("FAIL reset_cadru got=%b exp=0", cadru); end
    clr = 1'b1;
    @(negedge clk);
    checks++; if (cadru !== 1'b1) begin failures++; $display("FAIL first_cadru got=%b exp=1", cadru); end
    checks++; if (an !== 4'hF) begin failures++; $display("FAIL first_an got=%h exp=F", an); end
  endtask

  task automatic test_frame_1234;
    logic [3:0] ea[4];
    logic [6:0] es[4];
    logic [3:0] xa;
    logic [6:0] xs;
    ea[0] = 4'hE; ea[1] = 4'hD; ea[2] = 4'hB; ea[3] = 4'h7;
    es[0] = 7'h19; es[1] = 7'h30; es[2] = 7'h24; es[3] = 7'h79;
    for (int m = 1; m < 16; m++) begin
      @(negedge clk);
      xa = (m % 4 == 0) ? 4'hF : ea[m/4];
      xs = (m % 4 == 0) ? 7'h7F : es[m/4];
      checks++; if (an !== xa) begin failures++; $display("FAIL f1234_an m=%0d got=%h exp=%h", m, an, xa); end
      checks++; if (seg !== xs) begin failures++; $display("FAIL f1234_seg m=%0d got=%h exp=%h", m, seg, xs); end
      checks++; if (cadru !== (m == 15)) begin failures++; $display("FAIL f1234_cadru m=%0d got=%b", m, cadru); end
    end
  endtask

  task automatic test_blanking;
    logic [3:0] ea[4];
    logic [6:0] es[4];
    logic [3:0] xa;
    logic [6:0] xs;
    ea[0] = 4'hE; ea[1] = 4'hD; ea[2] = 4'hF; ea[3] = 4'hF;
    es[0] = 7'h40; es[1] = 7'h78; es[2] = 7'h7F; es[3] = 7'h7F;
    mii = 4'd0; sute = 4'd0; zeci = 4'd7; unitati = 4'd0;
    repeat (16) @(negedge clk);
    for (int m = 0; m < 16; m++) begin
      @(negedge clk);
      xa = (m % 4 == 0) ? 4'hF : ea[m/4];
      xs = (m % 4 == 0) ? 7'h7F : es[m/4];
      checks++; if (an !== xa) begin failures++; $display("FAIL blank_an m=%0d got=%h exp=%h", m, an, xa); end
      checks++; if (seg !== xs) begin failures++; $display("FAIL blank_seg m=%0d got=%h exp=%h", m, seg, xs); end
    end
  endtask

  task automatic test_all_zero;
    logic [3:0] ea[4];
    logic [3:0] eb[4];
    logic [3:0] xa, xb;
    logic [6:0] xs, xsb;
    ea[0] = 4'hE; ea[1] = 4'hF; ea[2] = 4'hF; ea[3] = 4'hF;
    eb[0] = 4'hE; eb[1] = 4'hD; eb[2] = 4'hB; eb[3] = 4'h7;
    mii = 4'd0; sute = 4'd0; zeci = 4'd0; unitati = 4'd0;
    repeat (16) @(negedge clk);
    for (int m = 0; m < 16; m++) begin
      @(negedge clk);
      xa  = (m % 4 == 0) ? 4'hF : ea[m/4];
      xs  = (m % 4 == 0 || m >= 4) ? 7'h7F : 7'h40;
      xb  = (m % 4 == 0) ? 4'hF : eb[m/4];
      xsb = (m % 4 == 0) ? 7'h7F : 7'h40;
      checks++; if (an !== xa) begin failures++; $display("FAIL zero_an m=%0d got=%h exp=%h", m, an, xa); end
      checks++; if (seg !== xs) begin failures++; $display("FAIL zero_seg m=%0d got=%h exp=%h", m, seg, xs); end
      checks++; if (an_b !== xb) begin failures++; $display("FAIL noblank_an m=%0d got=%h exp=%h", m, an_b, xb); end
      checks++; if (seg_b !== xsb) begin failures++; $display("FAIL noblank_seg m=%0d got=%h exp=%h", m, seg_b, xsb); end
    end
  endtask

  task automatic test_midframe_change;
    logic [3:0] xa;
    logic [6:0] xs;
    mii = 4'd0; sute = 4'd0; zeci = 4'd0; unitati = 4'd5;
    repeat (16) @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      for (int m = 0; m < 16; m++) begin
        @(negedge clk);
        xa = (m >= 1 && m <= 3) ? 4'hE : 4'hF;
        xs = (m >= 1 && m <= 3) ? ((f == 0) ? 7'h12 : 7'h10) : 7'h7F;
        checks++; if (an !== xa) begin failures++; $display("FAIL mid_an f=%0d m=%0d got=%h exp=%h", f, m, an, xa); end
        checks++; if (seg !== xs) begin failures++; $display("FAIL mid_seg f=%0d m=%0d got=%h exp=%h", f, m, seg, xs); end
        if (f == 0 && m == 4) unitati = 4'd9;
      end
    end
  endtask

  task automatic test_dash_enable;
    int gap;
    logic [3:0] xa;
    logic [6:0] xs;
    gap = 0;
    unitati = 4'd12;
    for (int f = 0; f < 3; f++) begin
      for (int m = 0; m < 16; m++) begin
        @(negedge clk);
        gap++;
        if (cadru === 1'b1) begin
          checks++; if (gap != 16) begin failures++; $display("FAIL cadru_gap got=%0d exp=16", gap); end
          gap = 0;
        end
        if (f >= 1) begin
          xa = (m >= 1 && m <= 3 && !(f == 1)) ? 4'hE : 4'hF;
          xs = (m >= 1 && m <= 3 && !(f == 1)) ? 7'h3F : 7'h7F;
          checks++; if (an !== xa) begin failures++; $display("FAIL en_an f=%0d m=%0d got=%h exp=%h", f, m, an, xa); end
          checks++; if (seg !== xs) begin failures++; $display("FAIL en_seg f=%0d m=%0d got=%h exp=%h", f, m, seg, xs); end
        end
        if (f == 1 && m == 0) en = 1'b0;
        if (f == 1 && m == 10) en = 1'b1;
      end
    end
    checks++; if (gap != 0) begin failures++; $display("FAIL cadru_last got_gap=%0d exp=0", gap); end
  endtask

  task automatic test_reset_midframe;
    unitati = 4'd8;
    repeat (9) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    checks++; if (an !== 4'hF) begin failures++; $display("FAIL rst_mid_an got=%h exp=F", an); end
    checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL rst_mid_seg got=%h exp=7F", seg); end
    checks++; if (cadru !== 1'b0) begin failures++; $display("FAIL rst_mid_cadru got=%b exp=0", cadru); end
    @(negedge clk);
    checks++; if (cadru !== 1'b1) begin failures++; $display("FAIL rst_rel_cadru got=%b exp=1", cadru); end
    for (int m = 1; m < 5; m++) begin
      @(negedge clk);
      checks++;
      if (an !== ((m == 4) ? 4'hF : 4'hE)) begin failures++; $display("FAIL rst_rel_an m=%0d got=%h", m, an); end
      checks++;
      if (seg !== ((m == 4) ? 7'h7F : 7'h00)) begin failures++; $display("FAIL rst_rel_seg m=%0d got=%h", m, seg); end
    end
  endtask

  initial begin
    test_reset;
    test_frame_1234;
    test_blanking;
    test_all_zero;
    test_midframe_change;
    test_dash_enable;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
